// File: rtl/multi_src_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multi_src_ctrl_pkg
// Shared definitions for the N-channel producer controller:
//   - state_t   : controller state encoding, also used by the LED/display decode
//   - W_DEF     : default data word width
//   - CNT_W_DEF : default word counter / limit width
// -----------------------------------------------------------------------------
package multi_src_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int W_DEF     = 16;
  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/multi_src_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// prio_enc
// Lowest-set-bit priority encoder.
// Ports:
//   req_i  in  N     request vector
//   idx_o  out CH_W  index of the lowest set bit (0 when nothing is set)
//   any_o  out 1     at least one request bit is set
// -----------------------------------------------------------------------------
module prio_enc #(
  parameter int N    = 4,
  parameter int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  output logic [CH_W-1:0] idx_o,
  output logic            any_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    for (int i = N - 1; i >= 0; i--) begin
      idx_o = req_i[i] ? CH_W'(i) : idx_o;
    end
  end

endmodule

// File: rtl/multi_src_ctrl.sv
// -----------------------------------------------------------------------------
// multi_src_ctrl
// Selects one of N producer channels on a start pulse, enables it, forwards its
// valid words into the CDC buffer write port, pauses while the buffer is full,
// stops on request or word limit, and drains the buffer before going idle.
// Ports:
//   clk, rst              clock (rising edge), async active-high reset
//   start[N]              one-cycle start pulses, bit i requests channel i
//   stop                  one-cycle stop pulse
//   limit[CNT_W]          word limit sampled at start, 0 = unlimited
//   src_valid[N]          per-channel valid
//   src_data[N*W]         packed channel data, channel i at [i*W +: W]
//   buf_full, buf_empty   CDC buffer status
//   sink_busy             read side still holding a word
//   src_en[N]             one-hot enable of the active channel (RUN only)
//   wr_en, wr_data[W]     buffer write port
//   active_ch[CH_W]       latched channel index
//   word_cnt[CNT_W]       words written in the current/last run
//   state_o[2]            current state
//   done                  one-cycle pulse, first IDLE cycle after draining
// -----------------------------------------------------------------------------
module multi_src_ctrl
  import multi_src_ctrl_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int CH_W  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       start,
  input  logic               stop,
  input  logic [CNT_W-1:0]   limit,
  input  logic [N-1:0]       src_valid,
  input  logic [N*W-1:0]     src_data,
  input  logic               buf_full,
  input  logic               buf_empty,
  input  logic               sink_busy,
  output logic [N-1:0]       src_en,
  output logic               wr_en,
  output logic [W-1:0]       wr_data,
  output logic [CH_W-1:0]    active_ch,
  output logic [CNT_W-1:0]   word_cnt,
  output logic [1:0]         state_o,
  output logic               done
);

  state_t             state_q, state_d;
  logic [CH_W-1:0]    active_ch_q, active_ch_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic               done_q, done_d;

  logic [CH_W-1:0]    start_idx_s;
  logic               start_any_s;
  logic               sel_valid_s;
  logic [W-1:0]       sel_data_s;
  logic               accept_s;
  logic               limit_hit_s;
  logic [CNT_W-1:0]   cnt_inc_s;

  prio_enc #(.N(N), .CH_W(CH_W)) u_start_enc (
    .req_i (start),
    .idx_o (start_idx_s),
    .any_o (start_any_s)
  );

  // Select valid/data of the latched channel; other channels are ignored.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_data_s  = '0;
    for (int i = 0; i < N; i++) begin
      sel_valid_s = (CH_W'(i) == active_ch_q) ? src_valid[i]       : sel_valid_s;
      sel_data_s  = (CH_W'(i) == active_ch_q) ? src_data[i*W +: W] : sel_data_s;
    end
  end

  assign accept_s  = (state_q == ST_RUN) && sel_valid_s && !buf_full;
  // Counter saturates at all-ones instead of wrapping.
  assign cnt_inc_s = (word_cnt_q == {CNT_W{1'b1}}) ? word_cnt_q : word_cnt_q + CNT_W'(1);
  // The word that reaches the limit is still written; the run ends after it.
  assign limit_hit_s = accept_s && (limit_q != '0) && ((word_cnt_q + CNT_W'(1)) == limit_q);

  // Next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    active_ch_d = active_ch_q;
    word_cnt_d  = word_cnt_q;
    limit_d     = limit_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_any_s) begin
          state_d     = ST_RUN;
          active_ch_d = start_idx_s;
          limit_d     = limit;
          word_cnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        word_cnt_d = accept_s ? cnt_inc_s : word_cnt_q;
        if (stop || limit_hit_s) begin
          state_d = ST_DRAIN;
        end else if (buf_full) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_DRAIN;
        end else if (!buf_full) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DRAIN: begin
        if (buf_empty && !sink_busy) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      active_ch_q <= '0;
      word_cnt_q  <= '0;
      limit_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_ch_q <= active_ch_d;
      word_cnt_q  <= word_cnt_d;
      limit_q     <= limit_d;
      done_q      <= done_d;
    end
  end

  assign src_en    = (state_q == ST_RUN) ? ({{(N-1){1'b0}}, 1'b1} << active_ch_q) : '0;
  assign wr_en     = accept_s;
  assign wr_data   = accept_s ? sel_data_s : '0;
  assign active_ch = active_ch_q;
  assign word_cnt  = word_cnt_q;
  assign state_o   = state_q;
  assign done      = done_q;

endmodule

// File: tb/tb_multi_src_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multi_src_ctrl
// Directed bench for multi_src_ctrl (N=4, W=16, CNT_W=16). Words expected on
// the write port are queued when driven and popped when wr_en is seen.
// -----------------------------------------------------------------------------
module tb_multi_src_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  start = '0;
  logic          stop = 1'b0;
  logic [15:0]   limit = '0;
  logic [N-1:0]  src_valid = '0;
  logic [N*W-1:0] src_data = 64'hBEEF_CAFE_F00D_DEAD;
  logic          buf_full = 1'b0;
  logic          buf_empty = 1'b1;
  logic          sink_busy = 1'b0;
  logic [N-1:0]  src_en;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic [1:0]    active_ch;
  logic [15:0]   word_cnt;
  logic [1:0]    state_o;
  logic          done;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] fib[5] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5};

  multi_src_ctrl #(.N(N), .W(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .limit(limit),
    .src_valid(src_valid), .src_data(src_data), .buf_full(buf_full),
    .buf_empty(buf_empty), .sink_busy(sink_busy), .src_en(src_en),
    .wr_en(wr_en), .wr_data(wr_data), .active_ch(active_ch),
    .word_cnt(word_cnt), .state_o(state_o), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: inspect the write port mid-cycle against the scoreboard,
  // then move to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("wr_unexpected", 64'(wr_en), 64'd0);
      else check("wr_data", 64'(wr_data), 64'(exp_q.pop_front()));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int ch, input logic [W-1:0] d);
    src_data[ch*W +: W] = d;
  endtask

  initial begin
    // ---------------- reset state ----------------
    #2 rst = 1'b1;
    #2;
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_src_en", 64'(src_en), 64'd0);
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_word_cnt", 64'(word_cnt), 64'd0);
    check("rst_active_ch", 64'(active_ch), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // ---------------- run on ch1, stop after 5 words ----------------
    start = 4'b0110; limit = 16'd0; buf_empty = 1'b0;
    tick();
    start = '0;
    check("t2_active_ch", 64'(active_ch), 64'd1);
    check("t2_src_en", 64'(src_en), 64'b0010);
    check("t2_state_run", 64'(state_o), 64'd1);
    src_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      set_data(1, fib[k]);
      exp_q.push_back(fib[k]);
      stop = (k == 4);
      #1;
      check("t2_wr_en", 64'(wr_en), 64'd1);
      tick();
    end
    stop = 1'b0;
    check("t2_state_drain", 64'(state_o), 64'd3);
    check("t2_word_cnt", 64'(word_cnt), 64'd5);
    check("t2_drain_src_en", 64'(src_en), 64'd0);
    check("t2_drain_wr_en", 64'(wr_en), 64'd0);
    tick();
    check("t2_drain_hold", 64'(state_o), 64'd3);
    buf_empty = 1'b1;
    #1;
    check("t2_done_early", 64'(done), 64'd0);
    tick();
    check("t2_state_idle", 64'(state_o), 64'd0);
    check("t2_done_pulse", 64'(done), 64'd1);
    tick();
    check("t2_done_clear", 64'(done), 64'd0);
    check("t2_idle_cnt_hold", 64'(word_cnt), 64'd5);
    check("t2_idle_ch_hold", 64'(active_ch), 64'd1);
    check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    // ---------------- word limit 3 on ch3 ----------------
    start = 4'b1000; limit = 16'd3; buf_empty = 1'b0;
    tick();
    start = '0;
    check("t3_active_ch", 64'(active_ch), 64'd3);
    check("t3_src_en", 64'(src_en), 64'b1000);
    for (int k = 0; k < 3; k++) begin
      set_data(3, 16'(100 + k));
      exp_q.push_back(16'(100 + k));
      #1;
      check("t3_wr_en", 64'(wr_en), 64'd1);
      tick();
    end
    check("t3_state_drain", 64'(state_o), 64'd3);
    check("t3_src_en_off", 64'(src_en), 64'd0);
    set_data(3, 16'd103);
    #1;
    check("t3_4th_dropped", 64'(wr_en), 64'd0);
    tick();
    check("t3_word_cnt", 64'(word_cnt), 64'd3);
    buf_empty = 1'b1;
    tick();
    check("t3_idle", 64'(state_o), 64'd0);
    check("t3_done", 64'(done), 64'd1);
    tick();

    // ---------------- buf_full for 4 cycles mid-run on ch0 ----------------
    start = 4'b0001; limit = 16'd0; buf_empty = 1'b0;
    tick();
    start = '0;
    for (int k = 0; k < 2; k++) begin
      set_data(0, 16'(200 + k));
      exp_q.push_back(16'(200 + k));
      tick();
    end
    set_data(0, 16'd202);
    buf_full = 1'b1;
    #1;
    check("t4_full_wr_en", 64'(wr_en), 64'd0);
    tick();
    for (int k = 0; k < 3; k++) begin
      check("t4_pause_state", 64'(state_o), 64'd2);
      check("t4_pause_src_en", 64'(src_en), 64'd0);
      check("t4_pause_wr_en", 64'(wr_en), 64'd0);
      tick();
    end
    buf_full = 1'b0;
    #1;
    check("t4_still_pause", 64'(state_o), 64'd2);
    check("t4_release_wr_en", 64'(wr_en), 64'd0);
    tick();
    check("t4_resume_state", 64'(state_o), 64'd1);
    check("t4_resume_src_en", 64'(src_en), 64'b0001);
    for (int k = 2; k < 4; k++) begin
      set_data(0, 16'(200 + k));
      exp_q.push_back(16'(200 + k));
      tick();
    end
    check("t4_word_cnt", 64'(word_cnt), 64'd4);

    // ---------------- stop while paused, sink busy after empty ----------------
    buf_full = 1'b1;
    tick();
    check("t5_pause", 64'(state_o), 64'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_drain", 64'(state_o), 64'd3);
    buf_full = 1'b0; buf_empty = 1'b1; sink_busy = 1'b1;
    tick();
    check("t5_busy1", 64'(state_o), 64'd3);
    tick();
    check("t5_busy2", 64'(state_o), 64'd3);
    sink_busy = 1'b0;
    #1;
    check("t5_done_early", 64'(done), 64'd0);
    tick();
    check("t5_idle", 64'(state_o), 64'd0);
    check("t5_done", 64'(done), 64'd1);
    check("t5_word_cnt", 64'(word_cnt), 64'd4);
    tick();

    // ---------------- start during RUN and stop in IDLE are ignored ----------------
    start = 4'b0100; buf_empty = 1'b0;
    tick();
    start = '0;
    check("t6_active_ch", 64'(active_ch), 64'd2);
    set_data(2, 16'h0300);
    exp_q.push_back(16'h0300);
    tick();
    start = 4'b0001;
    set_data(2, 16'h0301);
    exp_q.push_back(16'h0301);
    tick();
    start = '0;
    check("t6_ch_unchanged", 64'(active_ch), 64'd2);
    check("t6_state_run", 64'(state_o), 64'd1);
    check("t6_src_en", 64'(src_en), 64'b0100);
    src_valid = '0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    buf_empty = 1'b1;
    tick();
    check("t6_idle", 64'(state_o), 64'd0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t6_idle_stop_ignored", 64'(state_o), 64'd0);
    check("t6_cnt_hold", 64'(word_cnt), 64'd2);
    check("t6_ch_hold", 64'(active_ch), 64'd2);

    // ---------------- async reset mid-run ----------------
    start = 4'b0010; buf_empty = 1'b0;
    tick();
    start = '0;
    src_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      set_data(1, 16'(400 + k));
      exp_q.push_back(16'(400 + k));
      tick();
    end
    check("t1_pre_cnt", 64'(word_cnt), 64'd5);
    check("t1_pre_state", 64'(state_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_state", 64'(state_o), 64'd0);
    check("t1_rst_src_en", 64'(src_en), 64'd0);
    check("t1_rst_wr_en", 64'(wr_en), 64'd0);
    check("t1_rst_cnt", 64'(word_cnt), 64'd0);
    check("t1_rst_ch", 64'(active_ch), 64'd0);
    check("end_sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    src_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multi_src_ctrl.md
Name: multi_src_ctrl

Overview:
- Parametrised N-channel producer controller; successor to the fixed two-source (fibonacci/timer) control FSM in the top level.
- Selects one of N generator channels on a start pulse and gates that channel's enable.
- Forwards the channel's valid words into the CDC buffer write port, pauses while the buffer is full, and stops on request or on an optional word limit.
- Drains before returning to idle. Sits between the generators and the wrapper/async buffer, in the fast-clock domain.

Parameters:
- N, 4, number of producer channels (>=2).
- W, 16, data word width.
- CNT_W, 16, width of word counter and limit.
- CH_W, $clog2(N), width of the channel index.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  N  one-cycle start pulses, already edge-detected; bit i requests channel i.
- stop  in  1  one-cycle stop pulse, already edge-detected.
- limit  in  CNT_W  word limit, sampled on the start transition; 0 = unlimited.
- src_valid  in  N  per-channel output-valid.
- src_data  in  N*W  packed channel data; channel i occupies bits [i*W +: W].
- buf_full  in  1  CDC buffer full.
- buf_empty  in  1  CDC buffer empty.
- sink_busy  in  1  read side still holding a valid word (data_2_valid).
- src_en  out  N  one-hot enable to the active channel.
- wr_en  out  1  buffer write strobe.
- wr_data  out  W  buffer write data.
- active_ch  out  CH_W  latched channel index.
- word_cnt  out  CNT_W  words written in the current/last run.
- state_o  out  2  current state, for LEDs/display.
- done  out  1  one-cycle pulse on drain completion.

Behaviour:
- Reset (async): state IDLE. active_ch=0, word_cnt=0, latched limit=0, done=0.
  - Combinational outputs src_en, wr_en and wr_data evaluate to 0 while in IDLE.
- State encoding: IDLE=0, RUN=1, PAUSE=2, DRAIN=3. Registered FSM; next state is computed combinationally.
- IDLE:
  - If start!=0: latch the lowest set bit as active_ch, latch limit, clear word_cnt, go to RUN next cycle.
  - Simultaneous start bits: the lowest index wins; the others are discarded.
  - stop in IDLE is ignored.
- RUN:
  - src_en = onehot(active_ch). All other bits are 0.
  - Accept = src_valid[active_ch] & !buf_full.
  - wr_en = Accept, combinational, 0 cycles latency. wr_data = src_data slice of active_ch. Otherwise wr_data = 0.
  - Each accept increments word_cnt; it saturates at all-ones.
  - Priority, high to low:
    1. stop -> DRAIN.
    2. Limit hit (limit!=0 and an accept makes word_cnt+1==limit) -> DRAIN. That word is written.
    3. buf_full -> PAUSE.
  - Stop and accept in the same cycle: the word is written, then DRAIN.
- PAUSE:
  - src_en=0, wr_en=0.
  - stop -> DRAIN. Otherwise !buf_full -> RUN. Otherwise stay.
- DRAIN:
  - src_en=0, wr_en=0. Valid words arriving in DRAIN are dropped.
  - buf_empty & !sink_busy -> IDLE, with done=1 in the transition cycle (registered, visible the first IDLE cycle).
- Global rules:
  - start pulses outside IDLE are ignored.
  - word_cnt and active_ch hold their values in IDLE until the next start.
  - Only one channel is ever enabled, and only in RUN.
  - Async reset mid-run returns to IDLE immediately. Buffer contents are not this block's concern.
  - Inactive channels' src_valid is ignored.

Decomposition:
- Shared package:
  - state enum constants (ST_IDLE..ST_DRAIN) for the top-level LED/display decode.
  - Default widths W_DEF=16, CNT_W_DEF=16.
- Sub-module prio_enc:
  - N-bit lowest-set-bit priority encoder returning index (CH_W) and any-set flag.
  - Also reusable by the display mux.
- Mux and counter stay inline.

Test Plan:
1. Reset mid-RUN (word_cnt=5) -> asynchronously state_o=0, src_en=0, wr_en=0, word_cnt=0, no clock edge needed.
2. start=4'b0110, limit=0; ch1 valid every cycle, data 1,1,2,3,5; stop after 5 accepts; assert buf_empty & !sink_busy -> active_ch=1, src_en=4'b0010, wr_data sequence 1,1,2,3,5, word_cnt=5, state RUN->DRAIN->IDLE, done pulse exactly 1 cycle.
3. limit=3, start=4'b1000, ch3 valid every cycle -> exactly 3 wr_en, src_en drops the cycle after the 3rd write, 4th valid word not written, word_cnt=3.
4. buf_full asserted for 4 cycles mid-RUN -> wr_en=0 during full, state PAUSE, src_en=0; RUN resumes the cycle after full drops, word_cnt continues without loss or duplication.
5. stop while PAUSE, sink_busy high for 2 cycles after buf_empty -> stays DRAIN until sink_busy low, then IDLE + done.
6. start pulse during RUN on another channel, and stop in IDLE -> both ignored; active_ch unchanged, state unchanged.
